// File: rtl/lram_pkg.sv
// -----------------------------------------------------------------------------
// lram_pkg
// Shared constants, types and helpers for the LUTRAM-based FIFO slice.
//   LRAM_BANK_W    : data width of one RAM64M8-class bank
//   LRAM_MAX_DEPTH : word count of one bank address space
//   lram_addr_t    : physical bank address (full 64-word space)
//   lram_banks()   : number of banks needed for a given data width
// -----------------------------------------------------------------------------
package lram_pkg;

  localparam int LRAM_BANK_W    = 8;
  localparam int LRAM_MAX_DEPTH = 64;
  localparam int LRAM_MAX_AW    = $clog2(LRAM_MAX_DEPTH);

  // Physical bank address; logical FIFO pointers of AW bits zero-extend into it.
  typedef logic [LRAM_MAX_AW-1:0] lram_addr_t;

  // Number of 8-bit banks required to hold 'width' data bits.
  function automatic int lram_banks(input int width);
    return (width + LRAM_BANK_W - 1) / LRAM_BANK_W;
  endfunction

endpackage

// File: rtl/lram_array.sv
// -----------------------------------------------------------------------------
// lram_array
// Write-synchronous, read-asynchronous storage built from 8-bit x 64-word
// LUTRAM banks. Unused write-data bits of the last bank are tied low and the
// matching read bits are dropped; address bits above the FIFO depth are tied
// low so entries live in the low words of each bank.
// Ports:
//   clock : write clock (not inverted)
//   we    : write enable
//   waddr : write address, $clog2(DEPTH) bits
//   wdata : write data, WIDTH bits
//   raddr : read address, $clog2(DEPTH) bits
//   rdata : combinational read data, WIDTH bits
// -----------------------------------------------------------------------------
module lram_array
  import lram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  localparam int AW    = $clog2(DEPTH);
  localparam int BANKS = lram_banks(WIDTH);
  localparam int PW    = BANKS * LRAM_BANK_W;

  lram_addr_t    wa_s;
  lram_addr_t    ra_s;
  logic [PW-1:0] di_s;
  logic [PW-1:0] do_s;
  logic          unused_do_s;

  // Zero-extend addresses into the bank space and pad data to whole banks.
  always_comb begin
    wa_s           = '0;
    ra_s           = '0;
    di_s           = '0;
    wa_s[AW-1:0]   = waddr;
    ra_s[AW-1:0]   = raddr;
    di_s[WIDTH-1:0] = wdata;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [LRAM_BANK_W-1:0] mem_r [LRAM_MAX_DEPTH];

    // Synchronous write port of this bank.
    always_ff @(posedge clock) begin
      if (we) begin
        mem_r[wa_s] <= di_s[b*LRAM_BANK_W +: LRAM_BANK_W];
      end
    end

    assign do_s[b*LRAM_BANK_W +: LRAM_BANK_W] = mem_r[ra_s];
  end

  assign rdata = do_s[WIDTH-1:0];
  // Padding bits of the last bank carry nothing useful.
  assign unused_do_s = ^do_s;

endmodule

// File: rtl/lram_fifo.sv
// -----------------------------------------------------------------------------
// lram_fifo
// First-word-fall-through FIFO on distributed LUTRAM (see lram_array).
// Holds pointers, occupancy and the valid/ready handshakes; flags decode from
// the registered occupancy so there is no combinational in->out path.
// Build option:
//   LRAM_FIFO_OUT_REG_EN : adds a one-entry output register after the RAM.
//     out_valid/out_data come from flops, push-to-out_valid latency is 2,
//     capacity is DEPTH+1 and count includes the register entry.
// Ports:
//   clock     : single clock
//   reset     : synchronous, active-high
//   in_valid  / in_ready  / in_data  : producer handshake and data
//   out_valid / out_ready / out_data : consumer handshake and head entry
//   count     : current occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module lram_fifo
  import lram_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;
  logic             rd_adv_s;   // a word leaves the RAM this cycle
  logic [WIDTH-1:0] ram_do_s;

  lram_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clock (clock),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (in_data),
    .raddr (rd_ptr_r),
    .rdata (ram_do_s)
  );

`ifdef LRAM_FIFO_OUT_REG_EN
  logic [AW:0]      ram_cnt_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  // Back-pressure follows RAM occupancy only; the output register adds one slot.
  assign in_ready  = (ram_cnt_r != CNT_FULL);
  assign pop_s     = out_valid_r & out_ready;
  assign rd_adv_s  = (ram_cnt_r != '0) & (~out_valid_r | pop_s);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // RAM-resident entry count: +1 on write, -1 on transfer into the output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_cnt_r <= '0;
    end else begin
      case ({push_s, rd_adv_s})
        2'b10:   ram_cnt_r <= ram_cnt_r + CNT_ONE;
        2'b01:   ram_cnt_r <= ram_cnt_r - CNT_ONE;
        default: ram_cnt_r <= ram_cnt_r;
      endcase
    end
  end

  // Output register: refill from RAM whenever empty or being popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (rd_adv_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= ram_do_s;
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end
`else
  // Head entry is read straight out of the LUTRAM.
  assign in_ready  = (count_r != CNT_FULL);
  assign out_valid = (count_r != '0);
  assign pop_s     = out_valid & out_ready;
  assign rd_adv_s  = pop_s;
  assign out_data  = ram_do_s;
`endif

  assign push_s = in_valid & in_ready;
  assign count  = count_r;

  // Write/read pointers, wrapping naturally modulo DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_adv_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Total occupancy: +1 on push only, -1 on pop only.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
